// File: rtl/wb_trace_monitor_if.sv
// rtl/wb_trace_monitor_if.sv - core writeback/redirect tap and trace readout bundle
interface wb_trace_monitor_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int CYC_W  = 32
);
  // Core-side tap
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              br_taken;
  logic              jump;
  // Trace readout (show-ahead valid/ready)
  logic              rd_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic [CYC_W-1:0]  rd_cycle;

  modport master (
    output wb_en, wb_addr, wb_data, br_taken, jump, rd_ready,
    input  rd_valid, rd_addr, rd_data, rd_cycle
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, br_taken, jump, rd_ready,
    output rd_valid, rd_addr, rd_data, rd_cycle
  );
endinterface

// File: rtl/wb_trace_monitor.sv
// rtl/wb_trace_monitor.sv - writeback trace FIFO, run counters and pass/fail detector
module wb_trace_monitor #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 32,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     run_en,
  wb_trace_monitor_if.slave        bus,
  input  logic [ADDR_W-1:0]        watch_addr,
  input  logic [XLEN-1:0]          watch_data,
  input  logic [CYC_W-1:0]         timeout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CYC_W-1:0]         cycle_cnt,
  output logic [CYC_W-1:0]         wb_cnt,
  output logic [CYC_W-1:0]         redirect_cnt,
  output logic                     done,
  output logic                     pass,
  output logic                     fail
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ADDR_W + XLEN + CYC_W;
  localparam logic [CYC_W-1:0] CNT_MAX   = {CYC_W{1'b1}};
  localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);
  localparam bit               OVERWRITE = (MODE == 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t         state;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [EW-1:0]  head;

  logic active, commit, push, pop, full, match, tmo;
  logic wr_en, drop_old, lost, cnt_inc;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Event decode: capture only while actively running, never for x0
  always_comb begin
    active   = (state == S_RUN) && run_en;
    commit   = bus.wb_en && (bus.wb_addr != '0);
    push     = active && commit;
    pop      = (count != '0) && bus.rd_ready;
    full     = (count == FULL_CNT);
    match    = commit && (watch_addr != '0) && (bus.wb_addr == watch_addr)
               && (bus.wb_data == watch_data);
    tmo      = (timeout != '0) && (cycle_cnt == timeout - 1'b1);
    lost     = push && full && !pop;
    drop_old = lost && OVERWRITE;
    wr_en    = push && (!full || pop || OVERWRITE);
    cnt_inc  = wr_en && !drop_old;
  end

  // Run-state FSM, counters and end-of-test flags; pass beats timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cycle_cnt    <= '0;
      wb_cnt       <= '0;
      redirect_cnt <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      done         <= 1'b0;
    end else if (clr) begin
      state        <= S_IDLE;
      cycle_cnt    <= '0;
      wb_cnt       <= '0;
      redirect_cnt <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (run_en) state <= S_RUN;
        S_RUN: begin
          if (!run_en) begin
            state <= S_IDLE;
          end else begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (commit) wb_cnt <= sat_inc(wb_cnt);
            if (bus.br_taken || bus.jump) redirect_cnt <= sat_inc(redirect_cnt);
            if (match) begin
              state <= S_PASS;
              pass  <= 1'b1;
              done  <= 1'b1;
            end else if (tmo) begin
              state <= S_FAIL;
              fail  <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky loss flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop || drop_old) rd_ptr <= rd_ptr + 1'b1;
      if (cnt_inc && !pop) count <= count + 1'b1;
      else if (!cnt_inc && pop) count <= count - 1'b1;
      if (lost) overflow <= 1'b1;
    end
  end

  // Trace storage; stale contents are hidden by the occupancy gate on readout
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.wb_addr, bus.wb_data, cycle_cnt};
  end

  // Show-ahead head, forced to zero when empty
  always_comb begin
    head         = mem[rd_ptr];
    bus.rd_valid = (count != '0);
    bus.rd_addr  = '0;
    bus.rd_data  = '0;
    bus.rd_cycle = '0;
    if (bus.rd_valid) begin
      bus.rd_addr  = head[EW-1 -: ADDR_W];
      bus.rd_data  = head[CYC_W +: XLEN];
      bus.rd_cycle = head[CYC_W-1:0];
    end
  end
endmodule

// File: tb/tb_wb_trace_monitor.sv
// tb/tb_wb_trace_monitor.sv - directed scoreboard bench for both FIFO full policies
module tb_wb_trace_monitor;
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, clr, run_en;
  logic        wb_en, br_taken, jump, rd_ready;
  logic [4:0]  wb_addr, watch_addr;
  logic [31:0] wb_data, watch_data, timeout;

  logic [2:0]  count0, count1;
  logic        ovf0, ovf1, done0, done1, pass0, pass1, fail0, fail1;
  logic [31:0] cyc0, cyc1, wbc0, wbc1, red0, red1;

  int n_chk = 0;
  int n_fail = 0;

  ent_t q0[$];
  ent_t q1[$];
  int   mst;
  logic [31:0] mcyc, mwb, mred;
  logic mov0, mov1;
  logic [31:0] hold;

  always #5 clk = ~clk;

  wb_trace_monitor_if #(.XLEN(32), .ADDR_W(5), .CYC_W(32)) if0 ();
  wb_trace_monitor_if #(.XLEN(32), .ADDR_W(5), .CYC_W(32)) if1 ();

  assign if0.wb_en = wb_en;       assign if1.wb_en = wb_en;
  assign if0.wb_addr = wb_addr;   assign if1.wb_addr = wb_addr;
  assign if0.wb_data = wb_data;   assign if1.wb_data = wb_data;
  assign if0.br_taken = br_taken; assign if1.br_taken = br_taken;
  assign if0.jump = jump;         assign if1.jump = jump;
  assign if0.rd_ready = rd_ready; assign if1.rd_ready = rd_ready;

  wb_trace_monitor #(.XLEN(32), .ADDR_W(5), .DEPTH(4), .CYC_W(32), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .run_en(run_en), .bus(if0.slave),
    .watch_addr(watch_addr), .watch_data(watch_data), .timeout(timeout),
    .count(count0), .overflow(ovf0), .cycle_cnt(cyc0), .wb_cnt(wbc0),
    .redirect_cnt(red0), .done(done0), .pass(pass0), .fail(fail0)
  );

  wb_trace_monitor #(.XLEN(32), .ADDR_W(5), .DEPTH(4), .CYC_W(32), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .run_en(run_en), .bus(if1.slave),
    .watch_addr(watch_addr), .watch_data(watch_data), .timeout(timeout),
    .count(count1), .overflow(ovf1), .cycle_cnt(cyc1), .wb_cnt(wbc1),
    .redirect_cnt(red1), .done(done1), .pass(pass1), .fail(fail1)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q0.delete();
    q1.delete();
    mst = 0; mcyc = 0; mwb = 0; mred = 0; mov0 = 0; mov1 = 0;
  endtask

  task automatic mpush(input ent_t e);
    if (q0.size() < 4) q0.push_back(e);
    else mov0 = 1'b1;
    if (q1.size() == 4) begin
      void'(q1.pop_front());
      mov1 = 1'b1;
    end
    q1.push_back(e);
  endtask

  // Compare popped heads against the scoreboard, advance the model, then clock
  task automatic tick();
    ent_t e;
    bit act, com, m, t;
    if (rd_ready) begin
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("m0_valid", rd_valid_w(0), 1);
        check("m0_head", {if0.rd_addr, if0.rd_data, if0.rd_cycle}, e);
      end else check("m0_empty", rd_valid_w(0), 0);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("m1_valid", rd_valid_w(1), 1);
        check("m1_head", {if1.rd_addr, if1.rd_data, if1.rd_cycle}, e);
      end else check("m1_empty", rd_valid_w(1), 0);
    end
    act = (mst == 1) && run_en;
    com = wb_en && (wb_addr != 0);
    if (clr) mreset();
    else if (act) begin
      m = com && (watch_addr != 0) && (wb_addr == watch_addr) && (wb_data == watch_data);
      t = (timeout != 0) && (mcyc == timeout - 1);
      if (com) begin
        mpush({wb_addr, wb_data, mcyc});
        mwb++;
      end
      if (br_taken || jump) mred++;
      mcyc++;
      if (m) mst = 2;
      else if (t) mst = 3;
    end else if (mst == 0 && run_en) mst = 1;
    else if (mst == 1 && !run_en) mst = 0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rd_valid_w(input int which);
    return (which == 0) ? if0.rd_valid : if1.rd_valid;
  endfunction

  task automatic commit(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rd_ready = 1'b0;
    check("drain_cnt0", count0, 0);
    check("drain_cnt1", count1, 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_cyc"}, cyc0, mcyc);
    check({tag, "_wb"}, wbc0, mwb);
    check({tag, "_red"}, red0, mred);
    check({tag, "_cyc1"}, cyc1, mcyc);
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 0; run_en = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    br_taken = 0; jump = 0; rd_ready = 0; watch_addr = 0; watch_data = 0; timeout = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count0, 0);
    check("rst_valid", if0.rd_valid, 0);
    check("rst_flags", {done0, pass0, fail0, ovf0}, 0);
    check("rst_cyc", cyc0, 0);
    rst = 1'b1;

    // Basic capture
    run_en = 1'b1;
    tick();
    commit(5'd5, 32'h11);
    tick();
    commit(5'd6, 32'h22);
    check("basic_wb", wbc0, 2);
    check("basic_count", count0, 2);
    check("basic_head", {if0.rd_addr, if0.rd_data, if0.rd_cycle}, {5'd5, 32'h11, 32'd0});
    drain(2);
    check("basic_valid_low", if0.rd_valid, 0);

    // Redirect counting and run_en pause
    br_taken = 1; tick(); tick();
    br_taken = 0; jump = 1; tick();
    br_taken = 1; tick();
    br_taken = 0; jump = 0;
    check_model("redir");
    hold = cyc0;
    run_en = 0; tick(); tick(); tick();
    check("pause_hold", cyc0, hold);
    run_en = 1; tick(); tick();
    check("resume", cyc0, hold + 1);
    check_model("resume");

    // Pass and x0 filtering
    do_clr();
    check("clr_cyc", cyc0, 0);
    watch_addr = 5'd10; watch_data = 32'h2A;
    tick();
    commit(5'd0, 32'h2A);
    commit(5'd10, 32'h29);
    commit(5'd10, 32'h2A);
    check("pass_flags", {pass0, done0, fail0}, 3'b110);
    check("pass_wb", wbc0, 2);
    hold = cyc0;
    tick(); tick();
    check("pass_frozen", cyc0, hold);
    check("pass_count", count0, 2);
    drain(2);
    check_model("pass");
    do_clr();
    check("clr_pass", {pass0, done0, count0}, 0);

    // Timeout fail
    watch_addr = 0; timeout = 32'd8;
    tick();
    for (int i = 0; i < 20 && !fail0; i++) tick();
    check("fail_flag", {fail0, pass0, done0}, 3'b101);
    check("fail_cyc", cyc0, 8);
    check_model("fail");
    do_clr();

    // Pass and timeout on the same edge
    watch_addr = 5'd10; watch_data = 32'h2A;
    tick();
    repeat (7) tick();
    commit(5'd10, 32'h2A);
    check("prio_flags", {pass0, fail0}, 2'b10);
    check("prio_cyc", cyc0, 8);
    do_clr();

    // Overflow under both policies
    watch_addr = 0; timeout = 0;
    tick();
    for (int i = 1; i <= 6; i++) commit(5'(i), 32'h100 + i);
    check("ovf_count", {count0, count1}, {3'd4, 3'd4});
    check("ovf_flag", {ovf0, ovf1}, 2'b11);
    check("ovf_head", {if0.rd_addr, if1.rd_addr}, {5'd1, 5'd3});
    drain(4);
    do_clr();

    // Full with simultaneous pop and push
    tick();
    for (int i = 1; i <= 4; i++) commit(5'(i), 32'h200 + i);
    check("full_pre", {count0, ovf0}, {3'd4, 1'b0});
    rd_ready = 1;
    commit(5'd7, 32'h207);
    commit(5'd8, 32'h208);
    rd_ready = 0;
    check("full_pp_count", {count0, count1}, {3'd4, 3'd4});
    check("full_pp_ovf", {ovf0, ovf1}, 2'b00);
    drain(4);

    // Reset mid-run
    commit(5'd9, 32'h9);
    commit(5'd11, 32'hB);
    rst = 1'b0;
    #2;
    check("mid_rst_count", {count0, count1}, 0);
    check("mid_rst_valid", {if0.rd_valid, if0.rd_addr, if0.rd_data, if0.rd_cycle}, 0);
    check("mid_rst_cnts", {cyc0, wbc0, red0}, 0);
    check("mid_rst_flags", {done0, pass0, fail0, ovf0}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mreset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_trace_monitor.md
# wb_trace_monitor

Synthesisable, parametrised run monitor that sits beside the pipelined RISC-V core and taps its register-file write port and branch/jump redirect signals. It timestamps and buffers every committed writeback in a trace FIFO that can be drained through a valid/ready port. It keeps cycle, writeback and redirect counters, and declares end-of-test:

- **pass** on a programmable register/value match;
- **fail** on a programmable cycle timeout.

This replaces per-cycle register dumping with on-chip pass/fail detection.

## Interface
- XLEN, 32: register data width
- ADDR_W, 5: register address width
- DEPTH, 16: trace FIFO entries; power of two, ≥2
- CYC_W, 32: width of all counters and timestamps
- MODE, 0: trace FIFO full policy; 0 = STOP (drop new entry), 1 = OVERWRITE (drop oldest entry)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear: counters, FIFO, overflow, state→IDLE
- run_en  in  1  monitor enable
- wb_en  in  1  register-file write enable
- wb_addr  in  ADDR_W  register-file write address
- wb_data  in  XLEN  register-file write data
- br_taken  in  1  branch taken this cycle
- jump  in  1  jump this cycle
- watch_addr  in  ADDR_W  pass-condition register; 0 disables pass
- watch_data  in  XLEN  pass-condition value
- timeout  in  CYC_W  fail cycle limit; 0 disables fail
- rd_ready  in  1  trace consumer ready
- rd_valid  out  1  trace head valid
- rd_addr  out  ADDR_W  head entry register address
- rd_data  out  XLEN  head entry data
- rd_cycle  out  CYC_W  head entry timestamp
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a trace entry was lost
- cycle_cnt  out  CYC_W  cycles spent in RUN
- wb_cnt  out  CYC_W  committed writebacks
- redirect_cnt  out  CYC_W  cycles with br_taken or jump
- done / pass / fail  out  1 each  end-of-test flags

## Operation
- **States:** IDLE, RUN, PASS, FAIL.
- **Reset (rst=0):** state IDLE; all outputs, counters, pointers and flags are 0.
- **State transitions:**
  - IDLE→RUN when run_en=1.
  - RUN→IDLE when run_en=0; counters hold, and counting resumes on re-entry.
  - PASS and FAIL are terminal. They leave only on clr (→IDLE, everything zeroed) or reset.
  - clr has priority over every other event.
- **Committed write:** wb_en=1 and wb_addr≠0. Writes to x0 are never counted, traced or matched.
- **In RUN, each cycle:**
  - cycle_cnt += 1.
  - redirect_cnt += 1 if (br_taken | jump).
  - On a committed write: wb_cnt += 1, and push {wb_addr, wb_data, cycle_cnt (pre-increment value)} into the FIFO.
  - No capture or counting in IDLE, PASS or FAIL.
- **Counter saturation:** all counters saturate at 2^CYC_W−1; no wrap.
- **Pass event:** in RUN, committed write with watch_addr≠0, wb_addr==watch_addr and wb_data==watch_data. The matching write is itself traced and counted. Next state is PASS.
- **Fail event:** in RUN, timeout≠0 and cycle_cnt==timeout−1 (so cycle_cnt reaches timeout). Next state is FAIL.
- **Pass and fail in the same cycle:** PASS wins.
- **Flags:** pass = (state==PASS), fail = (state==FAIL), done = pass|fail.
- **FIFO read side:**
  - Show-ahead: rd_valid = (count≠0), and head fields are valid whenever rd_valid=1.
  - Pop on rd_valid & rd_ready.
  - Readout works in every state.
- **FIFO boundary cases:**
  - Push and pop in the same cycle: count unchanged.
  - Full, push, no pop, MODE=0: entry dropped, overflow←1.
  - Full, push, no pop, MODE=1: oldest entry discarded (read pointer advances), new entry written, count stays DEPTH, overflow←1.
  - Full with simultaneous pop and push: accepted in both modes, overflow unchanged.
  - Pop when empty: ignored.
- **Pointer wrap:** pointers wrap modulo DEPTH.

## Timing
- All state, counters, flags and FIFO updates occur on the rising clk edge. The only exception is rst, which acts asynchronously.
- **Capture latency:** 1 cycle. A write sampled at edge N appears at the head after edge N if the FIFO was empty.
- **pass/fail/done latency:** high in the cycle after the triggering edge, and held until clr or reset.
- **Counter visibility:** counter outputs are registered and reflect all events up to the last edge.
- **Reset mid-run:** immediate return to reset values; FIFO contents are discarded.
- **Deassert timing:** rst deassertion is synchronous to clk externally.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- **Basic capture:** reset, run_en=1, commits x5←0x11 at cycle 0, x6←0x22 at cycle 2 → drain gives (5,0x11,0) then (6,0x22,2); wb_cnt=2; rd_valid drops after the second pop.
- **Pass and x0 filtering:** watch_addr=10, watch_data=0x2A. Commit x0←0x2A, then x10←0x29, then x10←0x2A → pass=1 and done=1 the next cycle; wb_cnt=2; cycle_cnt frozen; x0 never traced.
- **Timeout and priority:** timeout=8, no match → fail=1 with cycle_cnt=8. Repeat with a matching write in the same cycle as the timeout → pass=1, fail=0.
- **Overflow, MODE=0:** DEPTH=4, 6 commits, no reads → count=4, overflow=1, drain yields entries 1–4. **Overflow, MODE=1:** same stimulus → drain yields entries 3–6.
- **Full with simultaneous pop and push:** rd_ready=1 on a full FIFO while pushing → count stays 4, overflow stays 0, order preserved.
- **Control sequencing:** run_en low for 3 cycles mid-run → counters hold, then resume. Assert rst mid-run → all outputs 0 immediately. clr in PASS → IDLE, count=0.
